i2c_txn_arbiter: RTL and testbench



---
 rtl/i2c_txn_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_i2c_txn_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_txn_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : i2c_txn_arbiter                                               |
// | Brief    : Round-robin arbiter that shares one single-byte I2C master    |
// |            engine between NUM_REQ requesters. It launches the winner's   |
// |            transaction, returns data/status and enforces a bus-free gap. |
// | Options  : define I2C_ARB_TIMEOUT_EN to enable the WAIT_BUSY/WAIT_DONE   |
// |            watchdog (sticky timeout_flag); otherwise it waits forever.   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+

module i2c_txn_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk_400,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [7*NUM_REQ-1:0]   req_addr,
  input  logic [NUM_REQ-1:0]     req_rw,
  input  logic [8*NUM_REQ-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [7:0]             rsp_rdata,
  output logic                   rsp_err,
  output logic                   timeout_flag,
  output logic                   m_start,
  output logic [7:0]             m_addr,
  output logic [7:0]             m_wdata,
  input  logic                   m_busy,
  input  logic                   m_done,
  input  logic [7:0]             m_rdata,
  input  logic                   m_ack_error
);

  localparam int c_IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int c_SUM_W = c_IDX_W + 1;
  localparam int c_GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LAUNCH    = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_RESPOND   = 3'd4,
    S_GAP       = 3'd5
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_IDX_W-1:0]   r_ptr;
  logic [c_IDX_W-1:0]   w_ptr_nxt;
  logic [c_GAP_W-1:0]   r_gap_cnt;
  logic [c_GAP_W-1:0]   w_gap_cnt_nxt;
  logic [NUM_REQ-1:0]   w_gnt_nxt;
  logic [7:0]           w_m_addr_nxt;
  logic [7:0]           w_m_wdata_nxt;
  logic [7:0]           w_rsp_rdata_nxt;
  logic                 w_rsp_err_nxt;
  logic                 w_tmo_hit;

  // Round-robin selection results
  logic                 w_found;
  logic [c_IDX_W-1:0]   w_sel;
  logic [c_SUM_W-1:0]   w_sum;
  logic [c_SUM_W-1:0]   w_sel_inc;
  logic [c_IDX_W-1:0]   w_sel_ptr_nxt;
  logic [NUM_REQ-1:0]   w_sel_onehot;
  logic [6:0]           w_sel_addr;
  logic                 w_sel_rw;
  logic [7:0]           w_sel_wdata;

  // Find the first pending request scanning upward from r_ptr with wrap.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_sum   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, r_ptr} + c_SUM_W'(k);
      if (w_sum >= c_SUM_W'(NUM_REQ)) begin
        w_sum = w_sum - c_SUM_W'(NUM_REQ);
      end
      if (!w_found && req[w_sum[c_IDX_W-1:0]]) begin
        w_found = 1'b1;
        w_sel   = w_sum[c_IDX_W-1:0];
      end
    end
  end

  // Winner's request fields and the pointer value that follows it.
  assign w_sel_onehot  = NUM_REQ'(1) << w_sel;
  assign w_sel_addr    = 7'(req_addr >> (7 * w_sel));
  assign w_sel_wdata   = 8'(req_wdata >> (8 * w_sel));
  assign w_sel_rw      = req_rw[w_sel];
  assign w_sel_inc     = {1'b0, w_sel} + c_SUM_W'(1);
  assign w_sel_ptr_nxt = (w_sel_inc == c_SUM_W'(NUM_REQ)) ? '0 : w_sel_inc[c_IDX_W-1:0];

  // Next-state and next-register values; everything holds unless a state acts.
  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_gap_cnt_nxt   = r_gap_cnt;
    w_gnt_nxt       = gnt;
    w_m_addr_nxt    = m_addr;
    w_m_wdata_nxt   = m_wdata;
    w_rsp_rdata_nxt = rsp_rdata;
    w_rsp_err_nxt   = rsp_err;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_gnt_nxt     = w_sel_onehot;
          w_m_addr_nxt  = {w_sel_addr, w_sel_rw};
          w_m_wdata_nxt = w_sel_wdata;
          w_ptr_nxt     = w_sel_ptr_nxt;
          w_state_nxt   = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        w_state_nxt = S_WAIT_BUSY;
      end
      S_WAIT_BUSY, S_WAIT_DONE: begin
        // A fast engine may signal done before ever showing busy.
        if (m_done) begin
          w_rsp_rdata_nxt = m_addr[0] ? m_rdata : 8'h00;
          w_rsp_err_nxt   = m_ack_error;
          w_state_nxt     = S_RESPOND;
        end else if (w_tmo_hit) begin
          w_rsp_rdata_nxt = 8'h00;
          w_rsp_err_nxt   = 1'b1;
          w_state_nxt     = S_RESPOND;
        end else if ((r_state == S_WAIT_BUSY) && m_busy) begin
          w_state_nxt = S_WAIT_DONE;
        end
      end
      S_RESPOND: begin
        w_gnt_nxt     = '0;
        w_gap_cnt_nxt = c_GAP_W'(GAP_CYCLES - 1);
        w_state_nxt   = S_GAP;
      end
      S_GAP: begin
        if (r_gap_cnt == '0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt - c_GAP_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register plus all latched request and response fields.
  always_ff @(posedge clk_400) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_gap_cnt <= '0;
      gnt       <= '0;
      m_addr    <= '0;
      m_wdata   <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_gap_cnt <= w_gap_cnt_nxt;
      gnt       <= w_gnt_nxt;
      m_addr    <= w_m_addr_nxt;
      m_wdata   <= w_m_wdata_nxt;
      rsp_rdata <= w_rsp_rdata_nxt;
      rsp_err   <= w_rsp_err_nxt;
    end
  end

  // Launch and response strobes decode directly from the registered state.
  assign m_start   = (r_state == S_LAUNCH);
  assign rsp_valid = gnt & {NUM_REQ{r_state == S_RESPOND}};

`ifdef I2C_ARB_TIMEOUT_EN
  logic [15:0] r_tmo_cnt;
  logic        w_waiting;

  assign w_waiting = (r_state == S_WAIT_BUSY) || (r_state == S_WAIT_DONE);
  assign w_tmo_hit = w_waiting && (r_tmo_cnt == 16'(TIMEOUT_CYCLES - 1));

  // Watchdog: restarts at launch, counts wait cycles, latches expiry.
  always_ff @(posedge clk_400) begin
    if (rst) begin
      r_tmo_cnt    <= '0;
      timeout_flag <= 1'b0;
    end else begin
      if (r_state == S_LAUNCH) begin
        r_tmo_cnt <= '0;
      end else if (w_waiting) begin
        r_tmo_cnt <= r_tmo_cnt + 16'd1;
      end
      if (w_tmo_hit && !m_done) begin
        timeout_flag <= 1'b1;
      end
    end
  end
`else
  logic w_unused_tmo_cfg;
  assign w_unused_tmo_cfg = (TIMEOUT_CYCLES != 0);
  assign w_tmo_hit        = 1'b0;
  assign timeout_flag     = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_i2c_txn_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_i2c_txn_arbiter                                            |
// | Brief    : Directed self-checking bench for i2c_txn_arbiter with an      |
// |            engine model and an expected-transaction scoreboard.          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps

module tb_i2c_txn_arbiter;

  localparam int NUM_REQ        = 4;
  localparam int GAP_CYCLES     = 4;
  localparam int TIMEOUT_CYCLES = 16;

  logic                 clk_400 = 1'b0;
  logic                 rst;
  logic [NUM_REQ-1:0]   req;
  logic [7*NUM_REQ-1:0] req_addr;
  logic [NUM_REQ-1:0]   req_rw;
  logic [8*NUM_REQ-1:0] req_wdata;
  logic [NUM_REQ-1:0]   gnt;
  logic [NUM_REQ-1:0]   rsp_valid;
  logic [7:0]           rsp_rdata;
  logic                 rsp_err;
  logic                 timeout_flag;
  logic                 m_start;
  logic [7:0]           m_addr;
  logic [7:0]           m_wdata;
  logic                 m_busy;
  logic                 m_done;
  logic [7:0]           m_rdata;
  logic                 m_ack_error;

  typedef struct packed {
    logic [NUM_REQ-1:0] gnt;
    logic [7:0]         addr;
    logic [7:0]         wdata;
    logic [7:0]         rdata;
    logic               err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   last_rsp_cyc   = -100;
  int   last_start_cyc = 0;
  int   n_starts = 0;
  int   eng_lat  = 40;
  bit   eng_fast = 1'b0;
  bit   eng_hang = 1'b0;
  bit   strict_gap = 1'b0;
  logic prev_start = 1'b0;
  logic [7:0] eng_addr;

  i2c_txn_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .GAP_CYCLES     (GAP_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk_400      (clk_400),
    .rst          (rst),
    .req          (req),
    .req_addr     (req_addr),
    .req_rw       (req_rw),
    .req_wdata    (req_wdata),
    .gnt          (gnt),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .timeout_flag (timeout_flag),
    .m_start      (m_start),
    .m_addr       (m_addr),
    .m_wdata      (m_wdata),
    .m_busy       (m_busy),
    .m_done       (m_done),
    .m_rdata      (m_rdata),
    .m_ack_error  (m_ack_error)
  );

  initial forever #5 clk_400 = ~clk_400;

  // Cycle counter used for gap and latency measurements.
  initial forever begin
    @(posedge clk_400);
    cyc = cyc + 1;
  end

  // Hard stop if the run stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed %0d cycles, expected < 20000", cyc);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rd_val(input logic [6:0] a);
    return 8'h3D ^ {1'b0, a};
  endfunction

  function automatic exp_t mk_exp(input logic [1:0] idx, input logic [6:0] a,
                                  input logic rw, input logic [7:0] wd);
    exp_t e;
    e.gnt   = 4'b0001 << idx;
    e.addr  = {a, rw};
    e.wdata = wd;
    e.rdata = rw ? rd_val(a) : 8'h00;
    e.err   = (a == 7'h7F);
    return e;
  endfunction

  task automatic set_req(input logic [1:0] idx, input logic [6:0] a,
                         input logic rw, input logic [7:0] wd);
    req_addr    = (req_addr & ~(28'h7F << (7 * idx))) | ({21'd0, a} << (7 * idx));
    req_wdata   = (req_wdata & ~(32'hFF << (8 * idx))) | ({24'd0, wd} << (8 * idx));
    req_rw[idx] = rw;
  endtask

  task automatic wait_rsp(input logic [1:0] idx);
    bit seen = 1'b0;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(negedge clk_400);
      if (rsp_valid[idx] === 1'b1) seen = 1'b1;
    end
    chk("rsp_arrived", seen, 1);
  endtask

  task automatic do_txn(input logic [1:0] idx, input logic [6:0] a, input logic rw,
                        input logic [7:0] wd, input bit drop_early);
    exp_t e;
    repeat (8) @(negedge clk_400);
    e = mk_exp(idx, a, rw, wd);
    set_req(idx, a, rw, wd);
    exp_q.push_back(e);
    req[idx] = 1'b1;
    @(negedge clk_400);
    chk("grant_latency", gnt, e.gnt);
    if (drop_early) begin
      req[idx] = 1'b0;
      set_req(idx, 7'h00, ~rw, 8'hFF);
    end
    wait_rsp(idx);
    req[idx] = 1'b0;
  endtask

  // Engine model: busy one cycle after m_start, done after eng_lat cycles.
  initial begin
    m_busy = 1'b0; m_done = 1'b0; m_rdata = 8'h00; m_ack_error = 1'b0;
    forever begin
      @(negedge clk_400);
      if (m_start === 1'b1) begin
        eng_addr = m_addr;
        @(negedge clk_400);
        if (eng_hang) begin
          m_busy = 1'b1;
          while (eng_hang) @(negedge clk_400);
          m_busy = 1'b0;
        end else begin
          if (!eng_fast) begin
            m_busy = 1'b1;
            repeat (eng_lat) @(negedge clk_400);
          end
          m_done      = 1'b1;
          m_rdata     = eng_addr[0] ? rd_val(eng_addr[7:1]) : 8'hEE;
          m_ack_error = (eng_addr[7:1] == 7'h7F);
          @(negedge clk_400);
          m_done = 1'b0; m_busy = 1'b0; m_rdata = 8'h00; m_ack_error = 1'b0;
        end
      end
    end
  end

  // Monitor: checks launches and responses against the scoreboard.
  initial forever begin
    @(negedge clk_400);
    if (m_start === 1'b1) begin
      n_starts++;
      last_start_cyc = cyc;
      chk("start_single", prev_start, 0);
      chk("start_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        chk("launch_gnt", gnt, exp_q[0].gnt);
        chk("launch_m_addr", m_addr, exp_q[0].addr);
        chk("launch_m_wdata", m_wdata, exp_q[0].wdata);
      end
      if (strict_gap) chk("gap_exact", cyc - last_rsp_cyc, GAP_CYCLES + 2);
      else            chk("gap_min", (cyc - last_rsp_cyc) >= GAP_CYCLES + 1, 1);
    end
    if (rsp_valid !== '0 && !$isunknown(rsp_valid)) begin
      chk("rsp_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("rsp_valid_onehot", rsp_valid, mon_e.gnt);
        chk("rsp_gnt_held", gnt, mon_e.gnt);
        chk("rsp_rdata", rsp_rdata, mon_e.rdata);
        chk("rsp_err", rsp_err, mon_e.err);
      end
      last_rsp_cyc = cyc;
    end
    prev_start = m_start;
  end

  initial begin
    int   cnt;
    bit   bad;
    exp_t e;
    rst = 1'b1; req = '0; req_rw = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk_400);
    chk("reset_outputs", {gnt, rsp_valid, rsp_rdata, rsp_err, timeout_flag, m_start, m_addr, m_wdata}, 0);
    rst = 1'b0;
    repeat (10) @(negedge clk_400);
    chk("idle_no_grant", gnt, 0);
    chk("idle_no_start", n_starts, 0);

    // Write from requester 1, slow engine.
    eng_lat = 40;
    do_txn(2'd1, 7'h01, 1'b0, 8'hA5, 1'b0);
    chk("one_start_for_write", n_starts, 1);

    // Read from requester 0.
    do_txn(2'd0, 7'h01, 1'b1, 8'h00, 1'b0);

    // Reset in the middle of WAIT_DONE.
    repeat (8) @(negedge clk_400);
    e = mk_exp(2'd2, 7'h33, 1'b1, 8'h77);
    set_req(2'd2, 7'h33, 1'b1, 8'h77);
    exp_q.push_back(e);
    req[2] = 1'b1;
    cnt = 0;
    while (m_busy !== 1'b1 && cnt < 20) begin
      @(negedge clk_400);
      cnt++;
    end
    chk("engine_busy_seen", m_busy, 1);
    repeat (5) @(negedge clk_400);
    exp_q.delete();
    rst = 1'b1; req[2] = 1'b0;
    @(negedge clk_400);
    chk("midtxn_reset_outputs", {gnt, rsp_valid, rsp_rdata, rsp_err, timeout_flag, m_start, m_addr, m_wdata}, 0);
    rst = 1'b0;
    bad = 1'b0;
    repeat (50) begin
      @(negedge clk_400);
      if (rsp_valid !== '0 || m_start !== 1'b0) bad = 1'b1;
    end
    chk("no_rsp_after_reset", bad, 0);

    // All four requesting: round-robin from pointer 0 after reset.
    eng_lat = 3;
    for (int k = 0; k < NUM_REQ; k++) set_req(2'(k), 7'h10 + 7'(k), k[0], 8'h50 + 8'(k));
    exp_q.push_back(mk_exp(2'd0, 7'h10, 1'b0, 8'h50));
    exp_q.push_back(mk_exp(2'd1, 7'h11, 1'b1, 8'h51));
    exp_q.push_back(mk_exp(2'd2, 7'h12, 1'b0, 8'h52));
    exp_q.push_back(mk_exp(2'd3, 7'h13, 1'b1, 8'h53));
    exp_q.push_back(mk_exp(2'd0, 7'h10, 1'b0, 8'h50));
    req = 4'b1111;
    cnt = 0;
    for (int k = 0; k < 1000 && cnt < 5; k++) begin
      @(negedge clk_400);
      if (rsp_valid !== '0) begin
        cnt++;
        strict_gap = 1'b1;
      end
    end
    req = '0;
    strict_gap = 1'b0;
    chk("rr_all_served", cnt, 5);
    chk("rr_queue_empty", exp_q.size(), 0);

    // NACK on 0x7F, then a clean read.
    eng_lat = 5;
    do_txn(2'd3, 7'h7F, 1'b0, 8'h11, 1'b0);
    do_txn(2'd2, 7'h10, 1'b1, 8'h00, 1'b0);

    // Fast engine (done without busy) and request dropped right after grant.
    eng_fast = 1'b1;
    do_txn(2'd1, 7'h22, 1'b1, 8'h00, 1'b1);
    eng_fast = 1'b0;

`ifdef I2C_ARB_TIMEOUT_EN
    // Engine never finishes: watchdog must answer with an error.
    repeat (8) @(negedge clk_400);
    eng_hang = 1'b1;
    e = mk_exp(2'd0, 7'h05, 1'b1, 8'h00);
    e.rdata = 8'h00;
    e.err   = 1'b1;
    set_req(2'd0, 7'h05, 1'b1, 8'h00);
    exp_q.push_back(e);
    req[0] = 1'b1;
    wait_rsp(2'd0);
    req[0] = 1'b0;
    chk("timeout_latency", (cyc - last_start_cyc) <= 18, 1);
    chk("timeout_flag_set", timeout_flag, 1);
    eng_hang = 1'b0;
    repeat (10) @(negedge clk_400);
    chk("timeout_flag_sticky", timeout_flag, 1);
    rst = 1'b1;
    @(negedge clk_400);
    rst = 1'b0;
    chk("timeout_flag_cleared", timeout_flag, 0);
`else
    chk("timeout_flag_tied", timeout_flag, 0);
`endif

    repeat (5) @(negedge clk_400);
    chk("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
